// File: rtl/framebuffer_scanout_pkg.sv
// Shared types for the framebuffer scanout path: pixel format, raster timing
// description and the per-position control bundle carried down the read pipeline.
package scanout_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] front;
        logic [15:0] sync;
        logic [15:0] back;
    } timing_t;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic frame_start;
        logic vblank_start;
    } scan_ctl_t;

    function automatic int scan_total(timing_t t);
        return int'(t.active) + int'(t.front) + int'(t.sync) + int'(t.back);
    endfunction

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port: address/strobe out, data back one clock after the strobe.
interface framebuffer_scanout_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [DATA_W-1:0] fb_rd_data;

    modport master (output fb_rd_en, output fb_rd_addr, input  fb_rd_data);
    modport slave  (input  fb_rd_en, input  fb_rd_addr, output fb_rd_data);
endinterface

// File: rtl/framebuffer_scanout_timing.sv
// Raster counters for the scanout path; all outputs describe the current (h,v)
// combinationally so the top can delay them in lockstep with the read data.
module display_timing_gen
    import scanout_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 100,
    parameter int DISPLAY_HEIGHT = 100,
    parameter int H_FRONT        = 4,
    parameter int H_SYNC         = 8,
    parameter int H_BACK         = 4,
    parameter int V_FRONT        = 2,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 2
) (
    input  logic      clk,
    input  logic      rst,
    output scan_ctl_t ctl
);
    localparam timing_t HT = '{active: 16'(DISPLAY_WIDTH), front: 16'(H_FRONT),
                               sync: 16'(H_SYNC), back: 16'(H_BACK)};
    localparam timing_t VT = '{active: 16'(DISPLAY_HEIGHT), front: 16'(V_FRONT),
                               sync: 16'(V_SYNC), back: 16'(V_BACK)};
    localparam int H_TOTAL = scan_total(HT);
    localparam int V_TOTAL = scan_total(VT);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(DISPLAY_WIDTH);
    localparam logic [HW-1:0] HS_ON  = HW'(DISPLAY_WIDTH + H_FRONT);
    localparam logic [HW-1:0] HS_OFF = HW'(DISPLAY_WIDTH + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(DISPLAY_HEIGHT);
    localparam logic [VW-1:0] VS_ON  = VW'(DISPLAY_HEIGHT + V_FRONT);
    localparam logic [VW-1:0] VS_OFF = VW'(DISPLAY_HEIGHT + V_FRONT + V_SYNC);

    logic [HW-1:0] h;
    logic [VW-1:0] v;

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    always_comb begin
        ctl              = '0;
        ctl.active       = (h < H_ACT) && (v < V_ACT);
        ctl.hsync        = (h >= HS_ON) && (h < HS_OFF);
        ctl.vsync        = (v >= VS_ON) && (v < VS_OFF);
        ctl.frame_start  = (h == '0) && (v == '0);
        ctl.vblank_start = (h == '0) && (v == V_ACT);
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Free-running framebuffer scanout: sequential reads, 2-clock aligned pixel stream.
// Optional front/back buffer swap at vblank under SCANOUT_DOUBLE_BUFFER_EN.
module framebuffer_scanout
    import scanout_pkg::*;
#(
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int H_FRONT               = 4,
    parameter int H_SYNC                = 8,
    parameter int H_BACK                = 4,
    parameter int V_FRONT               = 2,
    parameter int V_SYNC                = 2,
    parameter int V_BACK                = 2,
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    framebuffer_scanout_if.master            fb,
    output logic                             pixel_valid,
    output logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_data,
    output logic                             hsync,
    output logic                             vsync,
    output logic                             frame_start,
    output logic                             vblank_start
`ifdef SCANOUT_DOUBLE_BUFFER_EN
    ,
    input  logic                             swap_req,
    output logic                             swap_ack,
    output logic                             front_buf
`endif
);
    localparam int STAGES = 2;
    localparam logic [FRAMEBUFFER_ADDR_BITS-1:0] ADDR_LAST =
        FRAMEBUFFER_ADDR_BITS'(FRAMEBUFFER_SIZE - 1);

    scan_ctl_t                       ctl0;
    scan_ctl_t [STAGES:1]            vld_pipe;
    logic [FRAMEBUFFER_ADDR_BITS-1:0] rd_addr;

    display_timing_gen #(
        .DISPLAY_WIDTH (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
        .H_FRONT       (H_FRONT),
        .H_SYNC        (H_SYNC),
        .H_BACK        (H_BACK),
        .V_FRONT       (V_FRONT),
        .V_SYNC        (V_SYNC),
        .V_BACK        (V_BACK)
    ) u_timing (
        .clk(clk),
        .rst(rst),
        .ctl(ctl0)
    );

    // Stage 1 drives the read strobe; stage 2 lines up with the returned word.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], ctl0};
    end

    always_ff @(posedge clk) begin
        if (rst || ctl0.frame_start)
            rd_addr <= '0;
        else if (ctl0.active && rd_addr != ADDR_LAST)
            rd_addr <= rd_addr + FRAMEBUFFER_ADDR_BITS'(1);
    end

    assign fb.fb_rd_en   = vld_pipe[1].active;
    assign pixel_valid   = vld_pipe[STAGES].active;
    assign hsync         = vld_pipe[STAGES].hsync;
    assign vsync         = vld_pipe[STAGES].vsync;
    assign frame_start   = vld_pipe[STAGES].frame_start;
    assign vblank_start  = vld_pipe[STAGES].vblank_start;
    // The framebuffer's own output register is the stage-2 data flop.
    assign pixel_data    = pixel_valid ? fb.fb_rd_data : '0;

`ifdef SCANOUT_DOUBLE_BUFFER_EN
    logic              pending;
    logic              swap_now;
    logic [STAGES:1]   ack_pipe;

    // A request landing on the swap cycle itself is honoured immediately.
    assign swap_now = ctl0.vblank_start && (pending || swap_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            front_buf <= 1'b0;
        end else if (swap_now) begin
            pending   <= 1'b0;
            front_buf <= ~front_buf;
        end else if (swap_req) begin
            pending   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ack_pipe <= '0;
        else     ack_pipe <= {ack_pipe[STAGES-1:1], swap_now};
    end

    assign swap_ack      = ack_pipe[STAGES];
    assign fb.fb_rd_addr = {front_buf, rd_addr};
`else
    assign fb.fb_rd_addr = rd_addr;
`endif

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Randomized scanout bench: a position-based raster model predicts every output
// each cycle; a few literal values pin the model to the small test geometry.
module tb_framebuffer_scanout;
    localparam int W = 4, HGT = 3;
    localparam int HT = 8, VT = 6, FT = HT * VT;
    localparam int AW = 4;
`ifdef SCANOUT_DOUBLE_BUFFER_EN
    localparam int DB = 1;
`else
    localparam int DB = 0;
`endif
    localparam int RD_AW = AW + DB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic swap_req = 1'b0;
    logic        pixel_valid, hsync, vsync, frame_start, vblank_start;
    logic [15:0] pixel_data;
    logic        swap_ack_s, front_buf_s;
    logic [15:0] mem [0:(1<<RD_AW)-1];
    logic [15:0] rd_q;

    framebuffer_scanout_if #(.ADDR_W(RD_AW), .DATA_W(16)) fb ();

    framebuffer_scanout #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(HGT),
        .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .FRAMEBUFFER_DATA_BITS(16)
    ) dut (
        .clk(clk), .rst(rst), .fb(fb),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .vblank_start(vblank_start)
`ifdef SCANOUT_DOUBLE_BUFFER_EN
        , .swap_req(swap_req), .swap_ack(swap_ack_s), .front_buf(front_buf_s)
`endif
    );

`ifndef SCANOUT_DOUBLE_BUFFER_EN
    assign swap_ack_s  = 1'b0;
    assign front_buf_s = 1'b0;
`endif

    always #5 clk = ~clk;

    // Synchronous-read framebuffer: buffer 0 holds 0x1000+i, buffer 1 0x2000+i.
    initial for (int i = 0; i < (1 << RD_AW); i++)
        mem[i] = (i >= (1 << AW)) ? 16'(16'h2000 + i - (1 << AW)) : 16'(16'h1000 + i);
    always @(posedge clk) if (fb.fb_rd_en) rd_q <= mem[fb.fb_rd_addr];
    assign fb.fb_rd_data = rd_q;

    int n_checks = 0, n_fail = 0;
    int n = 0;
    bit started = 0;
    int phase = 0;
    bit front_m = 0, front_d1 = 0, pend_m = 0;
    int ack_at = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d after reset)", name, act, exp, n);
        end
    endtask

    function automatic int hpos(int p); return (p % FT) % HT; endfunction
    function automatic int vpos(int p); return (p % FT) / HT; endfunction
    function automatic bit is_act(int p); return hpos(p) < W && vpos(p) < HGT; endfunction

    // Model: n is the scan position the DUT counters hold this cycle.
    always @(posedge clk) begin
        if (rst) begin
            started = 1; n = 0;
            front_m = 0; front_d1 = 0; pend_m = 0; ack_at = -100;
        end else if (started) begin
            front_d1 = front_m;
            if (DB == 1) begin
                if (n % FT == HGT * HT) begin
                    if (pend_m || swap_req) begin
                        front_m = ~front_m; pend_m = 0; ack_at = n + 2;
                    end
                end else if (swap_req) pend_m = 1;
            end
            n = n + 1;
        end
    end

    int last_fs = -1, px_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            int p, q;
            bit e_act, e_hs, e_vs, e_fs, e_vb, e_en;
            logic [15:0] e_dat;
            p = n - 2; q = n - 1;
            e_act = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_vb = 0; e_dat = '0;
            if (p >= 0) begin
                e_act = is_act(p);
                e_hs  = hpos(p) >= 5 && hpos(p) < 7;
                e_vs  = vpos(p) == 4;
                e_fs  = (p % FT) == 0;
                e_vb  = (p % FT) == HGT * HT;
                if (e_act) e_dat = 16'((front_d1 ? 16'h2000 : 16'h1000) + vpos(p) * W + hpos(p));
            end
            e_en = (q >= 0) && is_act(q);
            chk("pixel_valid", pixel_valid, e_act);
            chk("pixel_data", pixel_data, e_dat);
            chk("hsync", hsync, e_hs);
            chk("vsync", vsync, e_vs);
            chk("frame_start", frame_start, e_fs);
            chk("vblank_start", vblank_start, e_vb);
            chk("fb_rd_en", fb.fb_rd_en, e_en);
            if (e_en)
                chk("fb_rd_addr", fb.fb_rd_addr, (DB ? int'(front_m) << AW : 0) + vpos(q) * W + hpos(q));
            if (DB == 1) begin
                chk("front_buf", front_buf_s, front_m);
                chk("swap_ack", swap_ack_s, n == ack_at);
            end

            if (phase == 0) begin
                if (n == 1) chk("lit_rd_en_first", fb.fb_rd_en, 1);
                if (n == 2) chk("lit_fs_first", frame_start, 1);
                if (n == 2) chk("lit_px_first", pixel_data, 16'h1000);
                if (n == 21) chk("lit_px_last", pixel_data, 16'h100B);
                if (n == 7) chk("lit_hsync_on", hsync, 1);
                if (n == 9) chk("lit_hsync_off", hsync, 0);
                if (n == 34) chk("lit_vsync", vsync, 1);
                if (n == 26) chk("lit_vblank", vblank_start, 1);
            end

            if (n == 0) begin last_fs = -1; px_cnt = 0; end
            if (vblank_start && last_fs >= 0) chk("fs_to_vblank", n - last_fs, 24);
            if (frame_start) begin
                if (last_fs >= 0) begin
                    chk("frame_period", n - last_fs, FT);
                    chk("px_per_frame", px_cnt, W * HGT);
                end
                last_fs = n; px_cnt = 0;
            end
            if (pixel_valid) px_cnt++;
        end
    end

    task automatic wait_n(input int target);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (n == target) return;
        end
        n_checks++; n_fail++;
        $display("FAIL wait_n: target %0d not reached, at %0d", target, n);
    endtask

    task automatic wait_vb(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (vblank_start) begin ok = 1; return; end
        end
        n_checks++; n_fail++;
        $display("FAIL wait_vb: no vblank_start seen");
    endtask

    task automatic pulse_swap();
        swap_req = 1; @(posedge clk); #1 swap_req = 0;
    endtask

    initial begin
        bit ok;
        int target, k;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        if (DB == 1) begin
            wait_n(3); pulse_swap();
            wait_vb(ok);
            if (ok) begin chk("db_ack1", swap_ack_s, 1); chk("db_front1", front_buf_s, 1); end
            wait_n(51); pulse_swap();
            wait_n(58); pulse_swap();
            wait_vb(ok);
            if (ok) begin chk("db_ack2", swap_ack_s, 1); chk("db_front2", front_buf_s, 0); end
            wait_vb(ok);
            if (ok) begin chk("db_ack3", swap_ack_s, 0); chk("db_front3", front_buf_s, 0); end
        end else begin
            wait_n(122);
        end

        // Reset in the middle of line 1.
        target = ((n / FT) + 1) * FT + 10;
        wait_n(target);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        phase = 1;
        k = 99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_start) begin k = i; break; end
        end
        chk("restart_fs_delay", k, 2);

        for (int it = 0; it < 8; it++) begin
            int cyc;
            cyc = $urandom_range(30, 150);
            repeat (cyc) begin
                @(posedge clk); #1;
                swap_req = (DB == 1) && ($urandom_range(0, 11) == 0);
            end
            swap_req = 0;
            rst = 1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 rst = 0;
        end
        repeat (150) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
